// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and the divide-by-zero quotient constant.
package muldiv_unit_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Wide enough for any supported WIDTH; sliced down at the use site.
    localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Multiply keeps {acc,q} as the partial product; divide keeps acc=remainder, q=dividend/quotient.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_sub;
    logic             fits;

    always_comb begin
        sum     = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : '0);
        shifted = {i_acc, i_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, i_m});
        // When the divisor fits, the difference is below the divisor, so WIDTH bits suffice.
        rem_sub = shifted[WIDTH-1:0] - i_m;
        if (i_is_div) begin
            o_acc = fits ? rem_sub : shifted[WIDTH-1:0];
            o_q   = {i_q[WIDTH-2:0], fits};
        end else begin
            o_acc = sum[WIDTH:1];
            o_q   = {sum[0], i_q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and busy/done handshake.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ITER_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
    logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [ITER_W-1:0]  cnt_q, cnt_d;
    logic               qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;

    logic               is_div, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   step_acc, step_q;
    logic [2*WIDTH-1:0] prod;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (is_div),
        .i_acc    (acc_q),
        .i_q      (q_q),
        .i_m      (m_q),
        .o_acc    (step_acc),
        .o_q      (step_q)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        done_d  = 1'b0;
        a_neg   = is_signed & a_q[WIDTH-1];
        b_neg   = is_signed & b_q[WIDTH-1];
        prod    = {acc_q, q_q};

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_PREP;
                    op_d    = i_op;
                    a_d     = i_a;
                    b_d     = i_b;
                end else begin
                    if (i_mthi) hi_d = i_a;
                    if (i_mtlo) lo_d = i_a;
                end
            end
            ST_PREP: begin
                q_d     = a_neg ? -a_q : a_q;
                m_d     = b_neg ? -b_q : b_q;
                acc_d   = '0;
                cnt_d   = '0;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div && b_q == '0) begin
                    hi_d = a_q;
                    lo_d = DIV0_LO[WIDTH-1:0];
                end else if (is_div) begin
                    hi_d = rneg_q ? -acc_q : acc_q;
                    lo_d = qneg_q ? -q_q : q_q;
                end else begin
                    if (qneg_q) prod = -prod;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
        end
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against an
// arithmetic reference model, and hand-written sequences for busy/reset corner cases.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .ITER_W(6)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .i_mthi  (mthi),
        .i_mtlo  (mtlo),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;   // {HI, LO}
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like the ISA.
    function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0] r;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = {32'h0, ma};
        ub = {32'h0, mb};
        case (mop)
            2'b00: r = sa * sb;
            2'b01: r = ua * ub;
            default: begin
                if (mb == 32'h0) r = {ma, 32'hFFFF_FFFF};
                else if (mop == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r = {sr[31:0], sq[31:0]};
                end else begin
                    sq = longint'(ua / ub);
                    sr = longint'(ua % ub);
                    r = {sr[31:0], sq[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] xa,
                         input logic [31:0] xb, input logic [63:0] exp, input logic mv);
        logic [63:0] hilo0;
        int busy_cycles;
        bit stable, overlap;
        @(negedge clk);
        hilo0 = {hi, lo};
        start = 1'b1; op = o; a = xa; b = xb; mthi = mv; mtlo = mv;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        a = $urandom; b = $urandom;
        busy_cycles = 0; stable = 1'b1; overlap = 1'b0;
        while (busy && busy_cycles < 100) begin
            busy_cycles++;
            if ({hi, lo} !== hilo0) stable = 1'b0;
            if (done) overlap = 1'b1;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 64'(busy_cycles), 64'd34);
        check({name, " hilo_stable"}, 64'(stable), 64'd1);
        check({name, " done_overlap"}, 64'(overlap), 64'd0);
        check({name, " done"}, 64'(done), 64'd1);
        check({name, " hilo"}, {hi, lo}, exp);
        @(negedge clk);
        check({name, " done_pulse"}, 64'(done), 64'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int dones;
        logic [1:0] rop;
        logic [31:0] ra, rb;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[3] = '{2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E};
        vecs[4] = '{2'b11, 32'h1234_5678, 32'h0,         64'h1234_5678_FFFF_FFFF};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[6] = '{2'b10, 32'hFFFF_FFFB, 32'h0,         64'hFFFF_FFFB_FFFF_FFFF};
        vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);

        for (int i = 0; i < 9; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: ra = 32'h0;
                1: ra = 32'h8000_0000;
                2: ra = 32'hFFFF_FFFF;
                3: ra = $urandom_range(0, 15);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h8000_0000;
                3: rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            do_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb), 1'($urandom_range(0, 1)));
        end

        // Start and MTHI while busy must both be ignored.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) begin
                start = 1'b1; op = 2'b11; a = 32'hAAAA; b = 32'd3; mthi = 1'b1;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                dones++;
                check("busy_ignore hilo", {hi, lo}, 64'd30);
            end
        end
        check("busy_ignore done_count", 64'(dones), 64'd1);
        check("busy_ignore idle", 64'(busy), 64'd0);

        mtlo = 1'b1; a = 32'h55;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo", {hi, lo}, 64'h0000_0000_0000_0055);
        mthi = 1'b1; mtlo = 1'b1; a = 32'h1234;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi_mtlo", {hi, lo}, 64'h0000_1234_0000_1234);

        // Reset mid-operation abandons the op and clears HI/LO.
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("midop busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst hilo", {hi, lo}, 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst no_done", 64'(dones), 64'd0);
        do_op("after_rst divu", 2'b11, 32'd9, 32'd3, 64'h0000_0000_0000_0003, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
